vga_framebuffer: RTL and testbench
==================================

Name: vga_framebuffer

Overview:
Double-buffered pixel store that sits directly upstream of the vga scan-out module. It answers the scan-out's address/data read port from the front bank with a fixed 1-cycle latency. The GPU side writes into the back bank and can issue a hardware clear of it. Bank swaps are requested by the GPU and committed only at the start of vertical sync, so a frame is never torn.

Parameters:
ADDR_W, 12, bank address width (scan-out addr width)
DATA_W, 8, pixel width (scan-out data width)
DEPTH, 4096, words per bank (2**ADDR_W)
VSYNC_ACTIVE, 0, level of vsync during the sync pulse

Ports:
clock  in  1  system clock (same clock as scan-out)
reset  in  1  synchronous, active-low reset
addr  in  ADDR_W  scan-out read address
data  out  DATA_W  front-bank word for addr sampled on the previous edge
vsync  in  1  vsync from scan-out
wr_valid  in  1  GPU pixel write request
wr_ready  out  1  pixel write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  back-bank write address
wr_data  in  DATA_W  back-bank write data
clr_valid  in  1  request fill of whole back bank
clr_ready  out  1  clear accepted when clr_valid && clr_ready
clr_value  in  DATA_W  fill value, captured on acceptance
clr_busy  out  1  clear sweep in progress
swap_req  in  1  single-cycle swap request
swap_pending  out  1  swap requested, not yet committed
front_sel  out  1  bank currently scanned out (0/1)

Behaviour:
- Reset (reset==0 at posedge): data=0, front_sel=0, swap_pending=0, clr_busy=0, FSM=IDLE, vsync history=inactive. wr_ready=0 and clr_ready=0 while reset is low. An in-progress clear is aborted and its partial bank contents are left as is.
- Read path: data <= bank[front_sel][addr] every cycle. Latency is exactly 1 clock with no stall. After a swap commits, the first read issued uses the new front_sel.
- Writes go only to bank[~front_sel]. Reads and writes always target different banks, so there is no read/write hazard.
- FSM states: IDLE and CLEAR.
- IDLE:
  - clr_ready=1.
  - wr_ready = ~clr_valid, so a clear takes priority over a write in the same cycle.
  - On clr_valid: latch clr_value, set clear counter=0, go to CLEAR.
- CLEAR:
  - Each cycle write the latched value to back[counter], then counter++.
  - wr_ready=0, clr_ready=0, clr_busy=1.
  - After writing DEPTH-1, return to IDLE. The sweep takes exactly DEPTH cycles.
- Swap request:
  - swap_req sets swap_pending on the next edge.
  - swap_req while pending has no effect; no queueing.
- Swap commit:
  - vsync is registered once. The sync-start edge is prev!=VSYNC_ACTIVE && cur==VSYNC_ACTIVE.
  - On that edge, if swap_pending && FSM==IDLE: toggle front_sel and clear swap_pending in the same edge.
  - If a clear is running, the swap waits for the next sync-start edge after the clear completes.
  - An edge with no pending swap does nothing.
- Simultaneous events:
  - A write accepted on the commit edge lands in the pre-swap back bank, which becomes the front bank.
  - swap_req on the commit edge is ignored if already pending. Otherwise it becomes pending for the next frame.
- No copy on swap: the new back bank holds the previous front frame.
- Widths: clear counter is ADDR_W+1 bits, or ADDR_W bits with a terminal compare at DEPTH-1. No wrap beyond the bank.

Decomposition:
- Package vga_fb_pkg holds ADDR_W/DATA_W/DEPTH defaults, the FSM state encoding (IDLE, CLEAR) and the VSYNC_ACTIVE default.
- Sub-module fb_bank: DEPTH x DATA_W simple dual-port RAM with one synchronous write port and one registered read port. Instantiate it twice. Output data is muxed by a front_sel copy registered alongside the read.

Test Plan:
- Reset then read: hold reset low 3 cycles, release, set addr=0x005 -> data=0 during reset; data = bank0[5] exactly 1 cycle after addr is presented.
- Write then swap:
  - Stimulus: write 0xA5 to 0x123 (back=bank1), pulse swap_req, drive vsync 1->0.
  - Response: swap_pending=1 until the edge; front_sel=1 one cycle after the edge; addr=0x123 -> data=0xA5 next cycle.
- Clear sweep: clr_valid with clr_value=0x3C -> clr_busy high for exactly 4096 cycles; wr_ready=0 throughout; after the swap every address 0..4095 reads 0x3C.
- Swap deferred by clear: start clear, pulse swap_req, vsync edge at sweep cycle 100 -> front_sel unchanged; next vsync edge after clr_busy falls -> front_sel toggles.
- Priority and collision: clr_valid and wr_valid together in IDLE -> wr_ready=0 and the write is not taken. swap_req while pending -> exactly one toggle at the next edge.
- Reset mid-clear: drop reset at sweep cycle 2000 -> clr_busy=0, FSM IDLE, front_sel=0 and swap_pending=0 the next cycle; a new clear completes normally.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared defaults and FSM encoding for the
// double-buffered scan-out framebuffer.
package vga_fb_pkg;

    localparam int   ADDR_W_DEF       = 12;
    localparam int   DATA_W_DEF       = 8;
    localparam int   DEPTH_DEF        = 4096;
    localparam logic VSYNC_ACTIVE_DEF = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_bank.sv
// fb_bank: DEPTH x DATA_W simple dual-port RAM.
// Ports: clock; we/waddr/wdata sync write; raddr -> rdata registered read.
module fb_bank
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: front bank feeds scan-out (addr -> data, 1 cycle),
// GPU writes/clears the back bank; swap commits at vsync start.
// Ports: clock, reset (sync, low); addr/data read; vsync;
// wr_valid/wr_ready/wr_addr/wr_data; clr_valid/clr_ready/clr_value/
// clr_busy; swap_req/swap_pending; front_sel.
module vga_framebuffer
    import vga_fb_pkg::*;
#(
    parameter int   ADDR_W       = ADDR_W_DEF,
    parameter int   DATA_W       = DATA_W_DEF,
    parameter int   DEPTH        = DEPTH_DEF,
    parameter logic VSYNC_ACTIVE = VSYNC_ACTIVE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_valid,
    output logic              clr_ready,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front_sel
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_val;
    logic              vs_prev;
    logic              rd_sel;
    logic              rd_ok;
    logic              sync_start;
    logic              commit;
    logic              bk_we;
    logic [ADDR_W-1:0] bk_addr;
    logic [DATA_W-1:0] bk_data;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    assign sync_start = (vs_prev != VSYNC_ACTIVE) && (vsync == VSYNC_ACTIVE);
    assign commit     = sync_start && swap_pending && (state == IDLE);

    assign clr_busy  = (state == CLEAR);
    assign clr_ready = reset && (state == IDLE);
    assign wr_ready  = reset && (state == IDLE) && !clr_valid;

    // One write port into whichever bank is currently at the back.
    always_comb begin
        bk_we   = 1'b0;
        bk_addr = wr_addr;
        bk_data = wr_data;
        if (reset && state == CLEAR) begin
            bk_we   = 1'b1;
            bk_addr = clr_cnt;
            bk_data = clr_val;
        end else if (wr_valid && wr_ready) begin
            bk_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            vs_prev      <= ~VSYNC_ACTIVE;
            rd_sel       <= 1'b0;
            rd_ok        <= 1'b0;
        end else begin
            vs_prev <= vsync;
            rd_ok   <= 1'b1;
            // Select copy travels with the RAM read so a swap never
            // mixes banks within one read.
            rd_sel  <= front_sel;
            if (commit) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (clr_valid) begin
                        clr_val <= clr_value;
                        clr_cnt <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fb_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
        .clock (clock),
        .we    (bk_we && front_sel),
        .waddr (bk_addr),
        .wdata (bk_data),
        .raddr (addr),
        .rdata (q0)
    );

    fb_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
        .clock (clock),
        .we    (bk_we && !front_sel),
        .waddr (bk_addr),
        .wdata (bk_data),
        .raddr (addr),
        .rdata (q1)
    );

    assign data = rd_ok ? (rd_sel ? q1 : q0) : '0;

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: directed scenarios for vga_framebuffer.
// Inputs change #1 after posedge; outputs are read at the same point.
module tb_vga_framebuffer;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data;
    logic          vsync = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_valid = 1'b0;
    logic          clr_ready;
    logic [DW-1:0] clr_value = '0;
    logic          clr_busy;
    logic          swap_req = 1'b0;
    logic          swap_pending;
    logic          front_sel;

    int total = 0;
    int bad = 0;

    vga_framebuffer dut (
        .clock        (clock),
        .reset        (reset),
        .addr         (addr),
        .data         (data),
        .vsync        (vsync),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .clr_valid    (clr_valid),
        .clr_ready    (clr_ready),
        .clr_value    (clr_value),
        .clr_busy     (clr_busy),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a clear and run it to completion; returns busy cycle count
    // and whether wr_ready was ever seen high while busy.
    task automatic sweep(input logic [DW-1:0] v, output int n,
                         output bit wr_seen);
        clr_value = v;
        clr_valid = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = '0;
        wr_data   = 8'hEE;
        tick();
        clr_valid = 1'b0;
        n = 0;
        wr_seen = 1'b0;
        while (clr_busy && n < 5000) begin
            if (wr_ready) wr_seen = 1'b1;
            n++;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic swap_now();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        addr = 12'h005;
        clr_valid = 1'b1;
        repeat (3) tick();
        total++; if (data !== 8'h00) begin bad++;
            $display("FAIL rst_data got %0h want 0", data); end
        total++; if (front_sel !== 1'b0) begin bad++;
            $display("FAIL rst_front got %0b want 0", front_sel); end
        total++; if (swap_pending !== 1'b0) begin bad++;
            $display("FAIL rst_pend got %0b want 0", swap_pending); end
        total++; if (clr_busy !== 1'b0) begin bad++;
            $display("FAIL rst_busy got %0b want 0", clr_busy); end
        total++; if (clr_ready !== 1'b0) begin bad++;
            $display("FAIL rst_clr_rdy got %0b want 0", clr_ready); end
        total++; if (wr_ready !== 1'b0) begin bad++;
            $display("FAIL rst_wr_rdy got %0b want 0", wr_ready); end
        clr_valid = 1'b0;
        reset = 1'b1;
        tick();
        total++; if (wr_ready !== 1'b1 || clr_ready !== 1'b1) begin bad++;
            $display("FAIL idle_rdy got %0b%0b want 11", wr_ready, clr_ready); end
    endtask

    task automatic test_clear();
        int n;
        bit ws;
        int err;
        sweep(8'h3C, n, ws);
        total++; if (n !== 4096) begin bad++;
            $display("FAIL clr_len got %0d want 4096", n); end
        total++; if (ws !== 1'b0) begin bad++;
            $display("FAIL clr_wr_rdy got %0b want 0", ws); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        total++; if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin bad++;
            $display("FAIL clr_pend got %0b/%0b want 1/0", swap_pending, front_sel); end
        vsync = 1'b0;
        tick();
        total++; if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin bad++;
            $display("FAIL clr_swap got %0b/%0b want 1/0", front_sel, swap_pending); end
        vsync = 1'b1;
        tick();
        err = 0;
        for (int a = 0; a < 4096; a++) begin
            addr = AW'(a);
            tick();
            if (data !== 8'h3C) err++;
        end
        total++; if (err !== 0) begin bad++;
            $display("FAIL clr_fill got %0d bad words want 0", err); end
        sweep(8'h5A, n, ws);
        total++; if (n !== 4096) begin bad++;
            $display("FAIL clr2_len got %0d want 4096", n); end
        swap_now();
        total++; if (front_sel !== 1'b0) begin bad++;
            $display("FAIL clr2_swap got %0b want 0", front_sel); end
    endtask

    task automatic test_write_swap();
        wr_addr = 12'h010;
        wr_data = 8'h66;
        wr_valid = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++;
            $display("FAIL ws_rdy got %0b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        total++; if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin bad++;
            $display("FAIL ws_wait got %0b/%0b want 1/0", swap_pending, front_sel); end
        vsync = 1'b0;
        wr_addr = 12'h123;
        wr_data = 8'hA5;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        total++; if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin bad++;
            $display("FAIL ws_commit got %0b/%0b want 1/0", front_sel, swap_pending); end
        vsync = 1'b1;
        addr = 12'h123;
        tick();
        total++; if (data !== 8'hA5) begin bad++;
            $display("FAIL ws_edge_wr got %0h want a5", data); end
        addr = 12'h010;
        #1;
        total++; if (data !== 8'hA5) begin bad++;
            $display("FAIL ws_latency got %0h want a5", data); end
        tick();
        total++; if (data !== 8'h66) begin bad++;
            $display("FAIL ws_wr got %0h want 66", data); end
        addr = 12'h124;
        tick();
        total++; if (data !== 8'h3C) begin bad++;
            $display("FAIL ws_old got %0h want 3c", data); end
    endtask

    task automatic test_priority();
        int n;
        clr_value = 8'h11;
        clr_valid = 1'b1;
        wr_valid = 1'b1;
        wr_addr = 12'h007;
        wr_data = 8'h99;
        #1;
        total++; if (wr_ready !== 1'b0 || clr_ready !== 1'b1) begin bad++;
            $display("FAIL pri_rdy got %0b%0b want 01", wr_ready, clr_ready); end
        tick();
        clr_valid = 1'b0;
        wr_valid = 1'b0;
        total++; if (clr_busy !== 1'b1) begin bad++;
            $display("FAIL pri_busy got %0b want 1", clr_busy); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (96) tick();
        vsync = 1'b0;
        tick();
        total++; if (front_sel !== 1'b1 || swap_pending !== 1'b1) begin bad++;
            $display("FAIL pri_defer got %0b/%0b want 1/1", front_sel, swap_pending); end
        vsync = 1'b1;
        n = 0;
        while (clr_busy && n < 5000) begin
            n++;
            tick();
        end
        total++; if (clr_busy !== 1'b0 || front_sel !== 1'b1) begin bad++;
            $display("FAIL pri_done got %0b/%0b want 0/1", clr_busy, front_sel); end
        vsync = 1'b0;
        tick();
        total++; if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin bad++;
            $display("FAIL pri_late got %0b/%0b want 0/0", front_sel, swap_pending); end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        total++; if (front_sel !== 1'b0) begin bad++;
            $display("FAIL pri_once got %0b want 0", front_sel); end
        vsync = 1'b1;
        addr = 12'h007;
        tick();
        total++; if (data !== 8'h11) begin bad++;
            $display("FAIL pri_fill got %0h want 11", data); end
        addr = 12'hFFF;
        tick();
        total++; if (data !== 8'h11) begin bad++;
            $display("FAIL pri_last got %0h want 11", data); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bit ws;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        clr_value = 8'h22;
        clr_valid = 1'b1;
        tick();
        clr_valid = 1'b0;
        repeat (1999) tick();
        total++; if (clr_busy !== 1'b1 || swap_pending !== 1'b1) begin bad++;
            $display("FAIL mid_pre got %0b/%0b want 1/1", clr_busy, swap_pending); end
        reset = 1'b0;
        tick();
        total++; if (clr_busy !== 1'b0 || swap_pending !== 1'b0 || front_sel !== 1'b0) begin bad++;
            $display("FAIL mid_rst got %0b%0b%0b want 000", clr_busy, swap_pending, front_sel); end
        total++; if (data !== 8'h00 || clr_ready !== 1'b0) begin bad++;
            $display("FAIL mid_rst_out got %0h/%0b want 0/0", data, clr_ready); end
        reset = 1'b1;
        addr = 12'h005;
        tick();
        total++; if (data !== 8'h11) begin bad++;
            $display("FAIL mid_read got %0h want 11", data); end
        sweep(8'h44, n, ws);
        total++; if (n !== 4096 || ws !== 1'b0) begin bad++;
            $display("FAIL mid_clr got %0d/%0b want 4096/0", n, ws); end
        swap_now();
        total++; if (front_sel !== 1'b1) begin bad++;
            $display("FAIL mid_swap got %0b want 1", front_sel); end
        addr = 12'h000;
        tick();
        total++; if (data !== 8'h44) begin bad++;
            $display("FAIL mid_first got %0h want 44", data); end
        addr = 12'hFFF;
        tick();
        total++; if (data !== 8'h44) begin bad++;
            $display("FAIL mid_last got %0h want 44", data); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_swap();
        test_priority();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
